mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares the single physical-memory port between the I-cache (fetch misses) and the D-cache
//   (misses and writebacks generated by LDR/LDB/LDI/STR/STB/STI).
// - Sits between the two cache miss ports and pmem.
// - Grants one requester at a time, holds the grant until pmem_resp, and breaks ties round-robin.
// - Also keeps per-port wait-cycle counters for stall accounting.
// PARAMETERS
// - ADDR_W  16   byte address width (lc3b_word)
// - LINE_W  128  cache line width (lc3b_cacheline)
// - CNT_W   32   wait-cycle counter width
// PORTS
// clk            in   1       system clock; all state updates on rising edge
// rst            in   1       synchronous, active-high reset
// i_mem_read     in   1       I-cache line read request; held until i_mem_resp
// i_mem_address  in   ADDR_W  I-cache line address
// i_mem_rdata    out  LINE_W  line data to I-cache
// i_mem_resp     out  1       I-cache transaction done
// d_mem_read     in   1       D-cache line read request; held until d_mem_resp
// d_mem_write    in   1       D-cache line writeback request; held until d_mem_resp
// d_mem_address  in   ADDR_W  D-cache line address
// d_mem_wdata    in   LINE_W  D-cache writeback data
// d_mem_rdata    out  LINE_W  line data to D-cache
// d_mem_resp     out  1       D-cache transaction done
// pmem_read      out  1       read to physical memory
// pmem_write     out  1       write to physical memory
// pmem_address   out  ADDR_W  physical memory address
// pmem_wdata     out  LINE_W  write data to physical memory
// pmem_rdata     in   LINE_W  read data from physical memory
// pmem_resp      in   1       physical memory done; 1-cycle pulse
// busy           out  1       a grant is active (state != IDLE)
// i_wait_cnt     out  CNT_W   cycles i_mem_read was high without i_mem_resp
// d_wait_cnt     out  CNT_W   cycles (d_mem_read|d_mem_write) was high without d_mem_resp
// BEHAVIOUR
// - States: IDLE, SERVE_I, SERVE_D. Registered state; last_grant register (0=I, 1=D).
// - Reset values:
//   - state=IDLE, last_grant=I (so D wins the first tie).
//   - Both counters=0.
//   - All outputs 0. rdata ports are 0 when their resp is 0.
// - IDLE:
//   - Only I requesting -> SERVE_I.
//   - Only D (read or write) requesting -> SERVE_D.
//   - Both requesting -> grant the port NOT equal to last_grant.
//   - Neither -> stay in IDLE.
//   - No pmem strobes in IDLE. Arbitration costs exactly 1 cycle: request seen at t, pmem strobe from t+1.
// - SERVE_I:
//   - pmem_read=1, pmem_write=0, pmem_address=i_mem_address.
//   - i_mem_resp=pmem_resp and i_mem_rdata=pmem_rdata (combinational pass-through).
//   - D outputs are held at 0.
//   - On pmem_resp: last_grant<=I, next state IDLE.
// - SERVE_D:
//   - pmem_read=d_mem_read, pmem_write=d_mem_write, pmem_address=d_mem_address, pmem_wdata=d_mem_wdata.
//   - d_mem_resp=pmem_resp and d_mem_rdata=pmem_rdata.
//   - On pmem_resp: last_grant<=D, next state IDLE.
// - Mandatory IDLE cycle after every resp: the requester drops its strobe in the cycle after resp,
//   so there are no back-to-back grants and no stale re-issue.
// - Grant never changes before pmem_resp, even if the other port requests.
//   A requester dropping its strobe mid-grant is illegal (bench asserts it); the arbiter still waits for pmem_resp.
// - d_mem_read and d_mem_write both high is illegal (assert). The arbiter forwards both unchanged.
// - pmem_wdata is 0 outside SERVE_D.
// - Counters: +1 per waiting cycle; saturate at all-ones (no wrap). Cleared only by rst.
// - rst mid-transaction: the next edge forces IDLE and zero outputs. The in-flight pmem access is
//   abandoned; pmem shares the same rst.
// STRUCTURE
// - lc3b_types gains: arb_state_t enum {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}.
//   lc3b_word and lc3b_cacheline already exist there and are used for the port types.
// - One sub-module, arb_rr_pick:
//   - Inputs: req_i, req_d, last_grant. Output: grant_d.
//   - Purely combinational tie-break, reused by the later L2/victim-buffer arbiter.
// - FSM next-state and output decode, plus the two counters, live in mem_arbiter.
// TESTING
// - I-only read 0x1230; pmem resp after 3 cycles -> pmem_read high t+1..t+4;
//   i_mem_resp 1 cycle with data; d_mem_resp=0.
// - D writeback 0x8040, wdata=128'hA5.. -> pmem_write=1, address 0x8040, wdata matches;
//   d_mem_resp on pmem_resp; pmem_read=0 throughout.
// - I and D request in the same cycle after reset -> D served first.
//   I waits, then is served after one IDLE cycle. i_wait_cnt equals the total I wait.
// - Both requesters held continuously for 4 transactions -> grants alternate D,I,D,I; neither starves.
// - I request arrives during SERVE_D -> no grant change and no I strobe until d_mem_resp plus IDLE.
// - rst asserted mid-SERVE_I -> next cycle state IDLE; all outputs, counters and busy are 0.
//   The first post-reset tie goes to D.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the memory arbiter slice.
//   lc3b_word      - byte address / machine word
//   lc3b_cacheline - one cache line
//   arb_state_t    - arbiter FSM states
//   arb_port_t     - requester identity, used for the round-robin history
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned LINE_W    = 128;
    localparam int unsigned ARB_CNT_W = 32;

    typedef logic [ADDR_W-1:0] lc3b_word;
    typedef logic [LINE_W-1:0] lc3b_cacheline;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_port_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the I-cache miss port, D-cache miss port,
// physical-memory port and the arbiter status outputs.
//   slave  - the arbiter's view (cache requests and pmem responses in)
//   master - the environment's view (caches + physical memory)
// CNT_W sets the width of the wait-cycle counters.
interface mem_arbiter_if #(
    parameter int unsigned CNT_W = mem_arbiter_pkg::ARB_CNT_W
) ();
    import mem_arbiter_pkg::*;

    // I-cache miss port
    logic          i_mem_read;
    lc3b_word      i_mem_address;
    lc3b_cacheline i_mem_rdata;
    logic          i_mem_resp;

    // D-cache miss / writeback port
    logic          d_mem_read;
    logic          d_mem_write;
    lc3b_word      d_mem_address;
    lc3b_cacheline d_mem_wdata;
    lc3b_cacheline d_mem_rdata;
    logic          d_mem_resp;

    // Physical memory port
    logic          pmem_read;
    logic          pmem_write;
    lc3b_word      pmem_address;
    lc3b_cacheline pmem_wdata;
    lc3b_cacheline pmem_rdata;
    logic          pmem_resp;

    // Status
    logic             busy;
    logic [CNT_W-1:0] i_wait_cnt;
    logic [CNT_W-1:0] d_wait_cnt;

    modport slave (
        input  i_mem_read, i_mem_address,
        output i_mem_rdata, i_mem_resp,
        input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
        output d_mem_rdata, d_mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp,
        output busy, i_wait_cnt, d_wait_cnt
    );

    modport master (
        output i_mem_read, i_mem_address,
        input  i_mem_rdata, i_mem_resp,
        output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
        input  d_mem_rdata, d_mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp,
        input  busy, i_wait_cnt, d_wait_cnt
    );

endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// arb_rr_pick: two-requester round-robin tie-break (combinational).
//   req_i, req_d - pending requests
//   last_grant   - port served most recently (GRANT_I / GRANT_D)
//   grant_d      - 1: D wins, 0: I wins; only meaningful when a request is pending
module arb_rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_d
);

    // D wins when it is alone, or on a tie when I was served last.
    always_comb begin
        grant_d = req_d & (~req_i | (last_grant == GRANT_I));
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single physical-memory port between the I-cache
// and D-cache miss ports. One requester is granted at a time and holds the
// grant until pmem_resp; ties are broken round-robin. An IDLE cycle always
// separates two grants. Per-port saturating wait-cycle counters are kept
// for stall accounting.
//   clk, rst - clock, synchronous active-high reset
//   bus      - mem_arbiter_if.slave: cache ports, pmem port, busy, counters
module mem_arbiter #(
    parameter int unsigned CNT_W = mem_arbiter_pkg::ARB_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    import mem_arbiter_pkg::*;

    arb_state_t       state_q, state_d;
    arb_port_t        last_grant_q, last_grant_d;
    logic [CNT_W-1:0] i_cnt_q, i_cnt_d;
    logic [CNT_W-1:0] d_cnt_q, d_cnt_d;

    logic req_i;
    logic req_d;
    logic grant_d;
    logic i_wait;
    logic d_wait;

    always_comb begin
        req_i = bus.i_mem_read;
        req_d = bus.d_mem_read | bus.d_mem_write;
    end

    arb_rr_pick u_rr_pick (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_grant_q),
        .grant_d    (grant_d)
    );

    // Output decode: strobes follow the registered state, responses and
    // read data are passed straight through from pmem to the granted port.
    always_comb begin
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = '0;
        bus.pmem_wdata   = '0;
        bus.i_mem_resp   = 1'b0;
        bus.i_mem_rdata  = '0;
        bus.d_mem_resp   = 1'b0;
        bus.d_mem_rdata  = '0;
        case (state_q)
            ARB_SERVE_I: begin
                bus.pmem_read    = 1'b1;
                bus.pmem_address = bus.i_mem_address;
                bus.i_mem_resp   = bus.pmem_resp;
                bus.i_mem_rdata  = bus.pmem_resp ? bus.pmem_rdata : '0;
            end
            ARB_SERVE_D: begin
                bus.pmem_read    = bus.d_mem_read;
                bus.pmem_write   = bus.d_mem_write;
                bus.pmem_address = bus.d_mem_address;
                bus.pmem_wdata   = bus.d_mem_wdata;
                bus.d_mem_resp   = bus.pmem_resp;
                bus.d_mem_rdata  = bus.pmem_resp ? bus.pmem_rdata : '0;
            end
            default: ;
        endcase
        bus.busy       = (state_q != ARB_IDLE);
        bus.i_wait_cnt = i_cnt_q;
        bus.d_wait_cnt = d_cnt_q;
    end

    // Next-state: the grant is only re-evaluated from IDLE, so a request
    // arriving mid-transaction never steals the port.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (req_i | req_d) begin
                    state_d = grant_d ? ARB_SERVE_D : ARB_SERVE_I;
                end
            end
            ARB_SERVE_I: begin
                if (bus.pmem_resp) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = GRANT_I;
                end
            end
            ARB_SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_d      = ARB_IDLE;
                    last_grant_d = GRANT_D;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Wait counters: a cycle counts when the port is requesting and not
    // being answered; they stick at all-ones instead of wrapping.
    always_comb begin
        i_wait  = bus.i_mem_read & ~bus.i_mem_resp;
        d_wait  = req_d & ~bus.d_mem_resp;
        i_cnt_d = (i_wait && (i_cnt_q != '1)) ? i_cnt_q + CNT_W'(1) : i_cnt_q;
        d_cnt_d = (d_wait && (d_cnt_q != '1)) ? d_cnt_q + CNT_W'(1) : d_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GRANT_I;
            i_cnt_q      <= '0;
            d_cnt_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            i_cnt_q      <= i_cnt_d;
            d_cnt_q      <= d_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A transaction-level
// reference (who owns pmem, who was served last, running wait totals) predicts
// every DUT output each cycle; directed scenarios add targeted checks and a
// randomized phase exercises mixed traffic. I-cache addresses keep bit 15
// clear and D-cache addresses keep it set, so the owner of pmem can be read
// off pmem_address.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned CW      = 6;
    localparam int          CNT_MAX = (1 << CW) - 1;
    localparam int          NONE    = 0;
    localparam int          PI      = 1;
    localparam int          PD      = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.CNT_W(CW)) bus ();

    mem_arbiter #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    int owner, prev, icnt, dcnt;
    bit chk_en;

    // environment (caches + pmem)
    bit          auto_en;
    int unsigned pct;
    int          pm_delay, cur_delay, pm_cnt;

    // per-cycle samples (taken at negedge)
    logic          s_pread, s_pwrite, s_busy, s_i_resp, s_d_resp, s_strobe;
    lc3b_word      s_addr;
    lc3b_cacheline s_wdata, s_i_rdata, s_d_rdata, s_pm_rdata;
    logic          last_busy;
    int            obs_log[$];

    // window observations
    logic [15:0]   m_pread, m_pwrite, m_iresp, m_dresp;
    lc3b_word      first_addr;
    lc3b_cacheline first_wdata, got_rdata, exp_rdata;
    int            first_i;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic          e_rd, e_wr, e_ir, e_dr, ireq, dreq;
        lc3b_word      e_addr;
        lc3b_cacheline e_wd;
        ireq   = bus.i_mem_read;
        dreq   = bus.d_mem_read | bus.d_mem_write;
        e_rd   = (owner == PI) || (owner == PD && bus.d_mem_read);
        e_wr   = (owner == PD) && bus.d_mem_write;
        e_ir   = (owner == PI) && bus.pmem_resp;
        e_dr   = (owner == PD) && bus.pmem_resp;
        e_addr = (owner == PI) ? bus.i_mem_address : (owner == PD) ? bus.d_mem_address : '0;
        e_wd   = (owner == PD) ? bus.d_mem_wdata : '0;
        check_eq("busy", bus.busy, owner != NONE);
        check_eq("pmem_read", bus.pmem_read, e_rd);
        check_eq("pmem_write", bus.pmem_write, e_wr);
        check_eq("pmem_address", bus.pmem_address, e_addr);
        check_eq("pmem_wdata", bus.pmem_wdata, e_wd);
        check_eq("i_mem_resp", bus.i_mem_resp, e_ir);
        check_eq("i_mem_rdata", bus.i_mem_rdata, e_ir ? bus.pmem_rdata : '0);
        check_eq("d_mem_resp", bus.d_mem_resp, e_dr);
        check_eq("d_mem_rdata", bus.d_mem_rdata, e_dr ? bus.pmem_rdata : '0);
        check_eq("i_wait_cnt", bus.i_wait_cnt, icnt);
        check_eq("d_wait_cnt", bus.d_wait_cnt, dcnt);
        // keep the compiler from flagging ireq/dreq as unused in some builds
        if (ireq === 1'bx || dreq === 1'bx) check_eq("req_known", {ireq, dreq}, 2'b00);
    endtask

    // Advance the reference by one clock using the values present at the edge.
    task automatic model_update();
        bit ireq, dreq, ir, dr;
        if (rst) begin
            owner = NONE; prev = PI; icnt = 0; dcnt = 0;
        end else begin
            ireq = bus.i_mem_read;
            dreq = bus.d_mem_read | bus.d_mem_write;
            ir   = (owner == PI) && bus.pmem_resp;
            dr   = (owner == PD) && bus.pmem_resp;
            if (ireq && !ir && icnt < CNT_MAX) icnt++;
            if (dreq && !dr && dcnt < CNT_MAX) dcnt++;
            if (owner == NONE) begin
                if (ireq && dreq)  owner = (prev == PD) ? PI : PD;
                else if (ireq)     owner = PI;
                else if (dreq)     owner = PD;
            end else if (bus.pmem_resp) begin
                prev  = owner;
                owner = NONE;
            end
        end
    endtask

    // Caches drop a request the cycle after its resp; pmem answers after
    // cur_delay strobe cycles with a one-cycle resp pulse.
    task automatic env_update();
        bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        if (rst) begin
            bus.i_mem_read  = 1'b0;
            bus.d_mem_read  = 1'b0;
            bus.d_mem_write = 1'b0;
            bus.pmem_resp   = 1'b0;
            pm_cnt          = 0;
            return;
        end
        if (bus.pmem_resp) begin
            bus.pmem_resp = 1'b0;
            pm_cnt        = 0;
        end else if (s_strobe) begin
            if (pm_cnt == 0) cur_delay = (pm_delay > 0) ? pm_delay : int'($urandom_range(1, 4));
            pm_cnt++;
            if (pm_cnt >= cur_delay) bus.pmem_resp = 1'b1;
        end
        if (bus.i_mem_read && s_i_resp) begin
            bus.i_mem_read = 1'b0;
        end else if (!bus.i_mem_read && auto_en && $urandom_range(0, 99) < pct) begin
            bus.i_mem_read    = 1'b1;
            bus.i_mem_address = {1'b0, 15'($urandom)};
        end
        if ((bus.d_mem_read || bus.d_mem_write) && s_d_resp) begin
            bus.d_mem_read  = 1'b0;
            bus.d_mem_write = 1'b0;
        end else if (!(bus.d_mem_read || bus.d_mem_write) && auto_en && $urandom_range(0, 99) < pct) begin
            if ($urandom_range(0, 1) == 1) bus.d_mem_write = 1'b1;
            else                           bus.d_mem_read  = 1'b1;
            bus.d_mem_address = {1'b1, 15'($urandom)};
            bus.d_mem_wdata   = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic tick();
        logic prev_i, prev_d;
        @(negedge clk);
        if (chk_en) check_outputs();
        s_pread    = bus.pmem_read;
        s_pwrite   = bus.pmem_write;
        s_strobe   = bus.pmem_read | bus.pmem_write;
        s_busy     = bus.busy;
        s_addr     = bus.pmem_address;
        s_wdata    = bus.pmem_wdata;
        s_i_resp   = bus.i_mem_resp;
        s_d_resp   = bus.d_mem_resp;
        s_i_rdata  = bus.i_mem_rdata;
        s_d_rdata  = bus.d_mem_rdata;
        s_pm_rdata = bus.pmem_rdata;
        if (chk_en) begin
            if (s_busy && !last_busy) obs_log.push_back(s_addr[15] ? PD : PI);
            last_busy = s_busy;
        end
        model_update();
        prev_i = bus.i_mem_read;
        prev_d = bus.d_mem_read | bus.d_mem_write;
        @(posedge clk);
        #1;
        env_update();
        if (!rst) begin
            if (prev_i && !bus.i_mem_read)
                assert (s_i_resp) else $error("I-cache dropped its request before i_mem_resp");
            if (prev_d && !(bus.d_mem_read || bus.d_mem_write))
                assert (s_d_resp) else $error("D-cache dropped its request before d_mem_resp");
        end
        assert (!(bus.d_mem_read && bus.d_mem_write)) else $error("d_mem_read and d_mem_write both high");
    endtask

    task automatic issue_i(input lc3b_word a);
        bus.i_mem_read    = 1'b1;
        bus.i_mem_address = a;
    endtask

    task automatic issue_d(input bit wr, input lc3b_word a, input lc3b_cacheline w);
        bus.d_mem_read    = !wr;
        bus.d_mem_write   = wr;
        bus.d_mem_address = a;
        bus.d_mem_wdata   = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        obs_log.delete();
        last_busy = 1'b0;
    endtask

    // Tick n cycles, recording per-cycle strobes/resps (bit k = k-th cycle).
    task automatic run_window(input int n);
        bit seen = 0;
        m_pread = '0; m_pwrite = '0; m_iresp = '0; m_dresp = '0;
        first_addr = '0; first_wdata = '0; got_rdata = '0; exp_rdata = '1;
        first_i = -1;
        for (int k = 0; k < n; k++) begin
            tick();
            m_pread[k]  = s_pread;
            m_pwrite[k] = s_pwrite;
            m_iresp[k]  = s_i_resp;
            m_dresp[k]  = s_d_resp;
            if ((s_pread || s_pwrite) && !seen) begin
                seen = 1; first_addr = s_addr; first_wdata = s_wdata;
            end
            if (s_pread && !s_addr[15] && first_i < 0) first_i = k;
            if (s_i_resp) begin got_rdata = s_i_rdata; exp_rdata = s_pm_rdata; end
            if (s_d_resp) begin got_rdata = s_d_rdata; exp_rdata = s_pm_rdata; end
        end
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        bit q = 0;
        for (int k = 0; k < budget; k++) begin
            q = !bus.i_mem_read && !bus.d_mem_read && !bus.d_mem_write &&
                !bus.pmem_resp && !bus.busy && owner == NONE;
            if (q) break;
            tick();
        end
        q = !bus.i_mem_read && !bus.d_mem_read && !bus.d_mem_write &&
            !bus.pmem_resp && !bus.busy && owner == NONE;
        check_eq({tag, "_quiesce"}, q, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq[4];
        exp_seq = '{PD, PI, PD, PI};
        rst = 1'b1;
        bus.i_mem_read = 1'b0; bus.i_mem_address = '0;
        bus.d_mem_read = 1'b0; bus.d_mem_write = 1'b0;
        bus.d_mem_address = '0; bus.d_mem_wdata = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
        chk_en = 0; auto_en = 0; pct = 0; pm_delay = 0; pm_cnt = 0; cur_delay = 1;
        last_busy = 1'b0; s_strobe = 1'b0; s_i_resp = 1'b0; s_d_resp = 1'b0;
        owner = NONE; prev = PI; icnt = 0; dcnt = 0;
        tick();
        chk_en = 1;
        tick();
        rst = 1'b0;

        // reset state
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_pmem_read", bus.pmem_read, 1'b0);
        check_eq("rst_i_wait_cnt", bus.i_wait_cnt, '0);
        check_eq("rst_d_wait_cnt", bus.d_wait_cnt, '0);

        // I-only read, pmem answers after 3 cycles
        pm_delay = 3;
        issue_i(16'h1230);
        run_window(8);
        check_eq("t1_pread_mask", m_pread[7:0], 8'h1E);
        check_eq("t1_iresp_mask", m_iresp[7:0], 8'h10);
        check_eq("t1_dresp_mask", m_dresp[7:0], 8'h00);
        check_eq("t1_addr", first_addr, 16'h1230);
        check_eq("t1_rdata", got_rdata, exp_rdata);
        wait_quiet(20, "t1");

        // D writeback
        pm_delay = 2;
        issue_d(1'b1, 16'h8040, {16{8'hA5}});
        run_window(8);
        check_eq("t2_pwrite_mask", m_pwrite[7:0], 8'h0E);
        check_eq("t2_pread_mask", m_pread[7:0], 8'h00);
        check_eq("t2_dresp_mask", m_dresp[7:0], 8'h08);
        check_eq("t2_addr", first_addr, 16'h8040);
        check_eq("t2_wdata", first_wdata, {16{8'hA5}});
        wait_quiet(20, "t2");

        // simultaneous requests after reset: D first, I after one IDLE cycle
        do_reset();
        pm_delay = 2;
        issue_i(16'h1000);
        issue_d(1'b0, 16'h9000, '0);
        run_window(10);
        check_eq("t3_grants", obs_log.size(), 2);
        if (obs_log.size() >= 2) begin
            check_eq("t3_first_grant", obs_log[0], PD);
            check_eq("t3_second_grant", obs_log[1], PI);
        end
        check_eq("t3_i_first_strobe", first_i, 5);
        check_eq("t3_dresp_mask", m_dresp[9:0], 10'h008);
        check_eq("t3_iresp_mask", m_iresp[9:0], 10'h080);
        wait_quiet(20, "t3");
        check_eq("t3_i_wait_cnt", bus.i_wait_cnt, 7);
        check_eq("t3_d_wait_cnt", bus.d_wait_cnt, 3);

        // both held continuously: grants alternate
        obs_log.delete();
        pm_delay = 0; pct = 100; auto_en = 1;
        for (int k = 0; k < 200 && obs_log.size() < 4; k++) tick();
        auto_en = 0;
        check_eq("t4_grant_count", obs_log.size() >= 4, 1'b1);
        for (int k = 0; k < 4; k++)
            if (k < obs_log.size()) check_eq($sformatf("t4_grant%0d", k), obs_log[k], exp_seq[k]);
        wait_quiet(40, "t4");

        // I request arrives during SERVE_D
        pm_delay = 4;
        issue_d(1'b0, 16'h8100, '0);
        run_window(2);
        issue_i(16'h0200);
        run_window(10);
        check_eq("t5_i_first_strobe", first_i, 5);
        wait_quiet(20, "t5");

        // reset in the middle of SERVE_I
        pm_delay = 4;
        issue_i(16'h0300);
        run_window(3);
        do_reset();
        check_eq("t6_busy", bus.busy, 1'b0);
        check_eq("t6_pmem_read", bus.pmem_read, 1'b0);
        check_eq("t6_pmem_address", bus.pmem_address, '0);
        check_eq("t6_i_wait_cnt", bus.i_wait_cnt, '0);
        check_eq("t6_d_wait_cnt", bus.d_wait_cnt, '0);
        pm_delay = 2;
        issue_i(16'h0400);
        issue_d(1'b0, 16'h8400, '0);
        wait_quiet(40, "t6");
        check_eq("t6_grants", obs_log.size(), 2);
        if (obs_log.size() >= 1) check_eq("t6_first_grant", obs_log[0], PD);

        // long pmem latency saturates both counters
        do_reset();
        pm_delay = 70;
        issue_i(16'h0500);
        issue_d(1'b1, 16'h8500, {$urandom, $urandom, $urandom, $urandom});
        wait_quiet(200, "t7");
        check_eq("t7_i_wait_sat", bus.i_wait_cnt, CNT_MAX);
        check_eq("t7_d_wait_sat", bus.d_wait_cnt, CNT_MAX);

        // randomized mixed traffic
        do_reset();
        pm_delay = 0; pct = 35; auto_en = 1;
        repeat (1500) tick();
        auto_en = 0;
        wait_quiet(60, "t8");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
